mopshub_rec_arbiter: RTL and testbench

- Sits between the 32 CAN bus receive controllers and the uplink elink framer inside mopshub_top_32bus.
- Scans the per-bus receive-pending flags with round-robin fairness and drives can_rec_select to read the chosen bus's 76-bit frame.
- Latches that frame and offers it to the elink framer through a valid/ready handshake.
- Clears the serviced bus's pending flag.

---
 rtl/mopshub_rec_pkg.sv | 24 ++
 rtl/rr_priority_pick.sv | 38 +++
 rtl/mopshub_rec_arbiter.sv | 147 ++++++++++++++
 tb/tb_mopshub_rec_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_rec_pkg.sv
// Shared types and constants for the MOPS-Hub receive arbiter.
// Frame layout matches the word presented by the CAN receive controllers.
package mopshub_rec_pkg;

    localparam int unsigned FRAME_W   = 76;
    localparam int unsigned BUS_SEL_W = 5;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWaitData,
        StPresent,
        StClear
    } rec_state_t;

    typedef struct packed {
        logic [6:0]  node_id;
        logic [3:0]  dlc;
        logic [63:0] payload;
        logic        crc_ok;
    } can_frame_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set bit of pending at or after start, wrapping to 0.
// Bits above n_buses are expected to be zero already, so wrapping at N_BUS-1 equals wrapping at n_buses.
module rr_priority_pick #(
    parameter int unsigned N_BUS = 32,
    parameter int unsigned SEL_W = 5
) (
    input  logic [N_BUS-1:0] pending,
    input  logic [SEL_W-1:0] start,
    input  logic [SEL_W-1:0] n_buses,
    output logic [SEL_W-1:0] index,
    output logic             found
);

    logic [SEL_W-1:0] base;
    logic [N_BUS-1:0] rotated;
    logic [SEL_W:0]   offset;
    logic [SEL_W+1:0] sum;

    always_comb begin
        // A start beyond the enabled range restarts the scan at bus 0.
        base    = (start > n_buses) ? '0 : start;
        rotated = N_BUS'({pending, pending} >> base);
        found   = 1'b0;
        offset  = '0;
        for (int i = N_BUS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = (SEL_W + 1)'(i);
            end
        end
        sum = {2'b00, base} + {1'b0, offset};
        if (sum >= (SEL_W + 2)'(N_BUS)) begin
            sum = sum - (SEL_W + 2)'(N_BUS);
        end
        index = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mopshub_rec_arbiter.sv
// Round-robin arbiter reading received CAN frames from up to N_BUS controllers
// and handing them one at a time to the uplink elink framer.
module mopshub_rec_arbiter
    import mopshub_rec_pkg::*;
#(
    parameter int unsigned N_BUS    = 32,
    parameter int unsigned DATA_W   = FRAME_W,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned SEL_W    = BUS_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  n_buses,
    input  logic [N_BUS-1:0]  irq_can_rec,
    input  logic [DATA_W-1:0] data_rec_in,
    output logic [SEL_W-1:0]  can_rec_select,
    output logic [N_BUS-1:0]  irq_clr,
    output logic [DATA_W-1:0] data_rec_uplink,
    output logic              uplink_valid,
    input  logic              uplink_ready,
    output logic              busy
);

    rec_state_t state_q, state_d;

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [N_BUS-1:0]  irq_clr_q, irq_clr_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;
    logic              lg_valid_q, lg_valid_d;
    logic              post_clear_q, post_clear_d;

    logic [N_BUS-1:0]  masked;
    logic [SEL_W-1:0]  start;
    logic [SEL_W-1:0]  pick;
    logic              found;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N_BUS; i++) begin
            masked[i] = irq_can_rec[i] && (SEL_W'(i) <= n_buses);
        end
        // The controller may still show the serviced flag for one cycle after the clear.
        if (post_clear_q && lg_valid_q) begin
            masked[last_grant_q] = 1'b0;
        end
        start = lg_valid_q ? last_grant_q + SEL_W'(1) : '0;
    end

    rr_priority_pick #(
        .N_BUS (N_BUS),
        .SEL_W (SEL_W)
    ) u_pick (
        .pending (masked),
        .start   (start),
        .n_buses (n_buses),
        .index   (pick),
        .found   (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (found) state_d = StSelect;
            StSelect:   state_d = StWaitData;
            StWaitData: if (cnt_q == '0) state_d = StPresent;
            StPresent:  if (uplink_ready) state_d = StClear;
            StClear:    state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        irq_clr_d    = '0;
        last_grant_d = last_grant_q;
        lg_valid_d   = lg_valid_q;
        post_clear_d = post_clear_q;
        unique case (state_q)
            StIdle: begin
                post_clear_d = 1'b0;
                if (found) sel_d = pick;
            end
            StSelect: cnt_d = CNT_W'(READ_LAT - 1);
            StWaitData: begin
                if (cnt_q == '0) begin
                    data_d  = data_rec_in;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StPresent: begin
                if (uplink_ready) begin
                    valid_d      = 1'b0;
                    irq_clr_d    = N_BUS'(1) << sel_q;
                    last_grant_d = sel_q;
                    lg_valid_d   = 1'b1;
                end
            end
            StClear: post_clear_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            irq_clr_q    <= '0;
            last_grant_q <= '0;
            lg_valid_q   <= 1'b0;
            post_clear_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            irq_clr_q    <= irq_clr_d;
            last_grant_q <= last_grant_d;
            lg_valid_q   <= lg_valid_d;
            post_clear_q <= post_clear_d;
        end
    end

    assign can_rec_select  = sel_q;
    assign irq_clr         = irq_clr_q;
    assign data_rec_uplink = data_q;
    assign uplink_valid    = valid_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_mopshub_rec_arbiter.sv
// Directed bench for mopshub_rec_arbiter with a READ_LAT-deep model of the external frame mux.
module tb_mopshub_rec_arbiter;

    localparam int unsigned N_BUS    = 32;
    localparam int unsigned DATA_W   = 76;
    localparam int unsigned READ_LAT = 2;
    localparam int unsigned SEL_W    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [SEL_W-1:0]  n_buses;
    logic [N_BUS-1:0]  irq_can_rec;
    logic [DATA_W-1:0] data_rec_in;
    logic [SEL_W-1:0]  can_rec_select;
    logic [N_BUS-1:0]  irq_clr;
    logic [DATA_W-1:0] data_rec_uplink;
    logic              uplink_valid;
    logic              uplink_ready;
    logic              busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mopshub_rec_arbiter #(
        .N_BUS    (N_BUS),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .SEL_W    (SEL_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .n_buses         (n_buses),
        .irq_can_rec     (irq_can_rec),
        .data_rec_in     (data_rec_in),
        .can_rec_select  (can_rec_select),
        .irq_clr         (irq_clr),
        .data_rec_uplink (data_rec_uplink),
        .uplink_valid    (uplink_valid),
        .uplink_ready    (uplink_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] frame_of(input logic [SEL_W-1:0] idx);
        return {12'hCA5, 32'hBEEF_0000 | {27'b0, idx}, {4{3'b000, idx}}};
    endfunction

    // External mux: data for a new select is valid READ_LAT cycles later.
    logic [SEL_W-1:0] sel_p1 = '0;
    logic [SEL_W-1:0] sel_p2 = '0;
    always @(posedge clk) begin
        sel_p1 <= can_rec_select;
        sel_p2 <= sel_p1;
    end
    assign data_rec_in = frame_of(sel_p2);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for uplink_valid, checks the frame, then checks the acceptance cycle (ready held high).
    task automatic serve(input int idx, input int exp_wait);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!uplink_valid && waited < 40);
        chk($sformatf("valid_seen_%0d", idx), uplink_valid, 1'b1);
        if (exp_wait > 0) chk($sformatf("wait_%0d", idx), waited, exp_wait);
        chk($sformatf("select_%0d", idx), can_rec_select, idx);
        chk($sformatf("data_%0d", idx), data_rec_uplink, frame_of(SEL_W'(idx)));
        @(negedge clk);
        chk($sformatf("irq_clr_%0d", idx), irq_clr, N_BUS'(1) << idx);
        chk($sformatf("valid_drop_%0d", idx), uplink_valid, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sel"}, can_rec_select, 0);
        chk({tag, "_clr"}, irq_clr, 0);
        chk({tag, "_data"}, data_rec_uplink, 0);
        chk({tag, "_valid"}, uplink_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hold_ok;
        int waited;

        rst          = 1'b1;
        n_buses      = '0;
        irq_can_rec  = '0;
        uplink_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Single pending bus 3: select one cycle later, valid READ_LAT+2 edges after sampling.
        n_buses      = 5'd31;
        uplink_ready = 1'b1;
        irq_can_rec  = 32'h0000_0008;
        @(negedge clk);
        chk("t1_select", can_rec_select, 3);
        chk("t1_busy", busy, 1'b1);
        chk("t1_valid_e0", uplink_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_e1", uplink_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_e2", uplink_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_e3", uplink_valid, 1'b1);
        chk("t1_data", data_rec_uplink, frame_of(5'd3));
        chk("t1_clr_early", irq_clr, 0);
        @(negedge clk);
        chk("t1_clr_pulse", irq_clr, 32'h8);
        chk("t1_valid_drop", uplink_valid, 1'b0);
        chk("t1_busy_clear", busy, 1'b1);
        irq_can_rec = '0;
        @(negedge clk);
        chk("t1_clr_end", irq_clr, 0);
        chk("t1_idle", busy, 1'b0);

        // Reset restarts the scan at bus 0; buses 2, 5, 9 held pending.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        irq_can_rec = (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 9);
        serve(2, -1);
        serve(5, 5);
        serve(9, 5);
        serve(2, 5);
        serve(5, 5);
        serve(9, 5);

        // All flags set but only buses 0..7 enabled; last grant 9 lies beyond, scan restarts at 0.
        n_buses     = 5'd7;
        irq_can_rec = '1;
        for (int i = 0; i < 8; i++) serve(i, 5);
        serve(0, 5);
        serve(1, 5);

        // Back-pressure: ready low for 50 cycles while presenting bus 4.
        n_buses      = 5'd31;
        irq_can_rec  = 32'd1 << 4;
        uplink_ready = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!uplink_valid && waited < 40);
        chk("bp_valid_seen", uplink_valid, 1'b1);
        chk("bp_wait", waited, 5);
        hold_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(uplink_valid && can_rec_select == 5'd4 && irq_clr == '0 &&
                  data_rec_uplink == frame_of(5'd4) && busy)) hold_ok = 1'b0;
        end
        chk("bp_hold_stable", hold_ok, 1'b1);
        uplink_ready = 1'b1;
        @(negedge clk);
        chk("bp_clr", irq_clr, 32'h10);
        chk("bp_valid_drop", uplink_valid, 1'b0);

        // Reset during WAIT_DATA drops the frame without a clear; rescan starts from 0.
        irq_can_rec = (32'd1 << 6) | (32'd1 << 1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_select", can_rec_select, 6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        serve(1, -1);
        serve(6, 5);

        // Wrap-around from bus 31 to bus 0 and back.
        irq_can_rec = 32'd1 << 31;
        serve(31, 5);
        irq_can_rec = (32'd1 << 31) | 32'd1;
        serve(0, 5);
        serve(31, 5);

        // n_buses = 0: only bus 0 eligible; a held flag waits out the post-clear cycle.
        n_buses     = 5'd0;
        irq_can_rec = (32'd1 << 5) | 32'd1;
        serve(0, 5);
        serve(0, 6);
        irq_can_rec = '0;
        repeat (10) @(negedge clk);
        chk("final_busy", busy, 1'b0);
        chk("final_clr", irq_clr, 0);
        chk("final_valid", uplink_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
